stream_packer: RTL

//  Downstream consumer of the 4-deep shift-register stage. Collects RATIO consecutive
//  D_WIDTH-bit words from a valid/ready stream and emits one RATIO*D_WIDTH-bit word
//  on a valid/ready output. Sustains 1 input word/cycle when the sink never stalls.

---
 rtl/stream_pkg.sv | 17 +
 rtl/pack_out_reg.sv | 33 +++
 rtl/stream_packer.sv | 110 +++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream packer.
// Optional feature macro: PACK_FLUSH_EN (early close via up_last).
package stream_pkg;

  localparam int D_WIDTH_DEF = 6;
  localparam int RATIO_DEF   = 4;

  // Lane counter width; a 1-bit floor keeps degenerate ratios well formed.
  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  localparam int CNT_W_DEF = cnt_width(RATIO_DEF);

  typedef logic [RATIO_DEF-1:0] lane_mask_t;

endpackage

// File: rtl/pack_out_reg.sv
// Output holding register for the packer: loads a packed payload, holds it
// while the sink stalls, and drops valid on a pop with no new load.
// Payload carries data plus keep/last when PACK_FLUSH_EN is defined.
module pack_out_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] payload_in,
  input  logic         sink_ready,
  output logic [W-1:0] payload,
  output logic         valid
);

  logic pop;

  assign pop = valid & sink_ready;

  // Load wins over pop so a same-cycle pop+load keeps valid high with no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      payload <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      payload <= payload_in;
      valid   <= 1'b1;
    end else if (pop) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Packs RATIO consecutive D_WIDTH-bit words into one RATIO*D_WIDTH-bit word.
// Lane 0 is filled first. Optional macro PACK_FLUSH_EN adds up_last (early
// close), down_keep (lanes holding real data) and down_last.
module stream_packer
  import stream_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int RATIO   = RATIO_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_WIDTH-1:0]         up_data,
  input  logic                       up_valid,
  output logic                       up_ready,
  output logic [RATIO*D_WIDTH-1:0]   down_data,
  output logic                       down_valid,
`ifdef PACK_FLUSH_EN
  input  logic                       up_last,
  output logic [RATIO-1:0]           down_keep,
  output logic                       down_last,
`endif
  input  logic                       down_ready
);

  localparam int CW = cnt_width(RATIO);
  localparam int W  = RATIO * D_WIDTH;
`ifdef PACK_FLUSH_EN
  localparam int PW = W + RATIO + 1;
`else
  localparam int PW = W;
`endif

  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic          ready_en;
  logic          last_lane;
  logic          closing;
  logic          accept;
  logic          load;
  logic [W-1:0]  packed_word;
  logic [PW-1:0] payload_in;
  logic [PW-1:0] payload;

  assign last_lane = (cnt == CW'(RATIO - 1));
`ifdef PACK_FLUSH_EN
  assign closing   = last_lane | up_last;
`else
  assign closing   = last_lane;
`endif

  // ready_en keeps up_ready low during reset and until the first edge after release.
  assign up_ready    = ready_en & ~(closing & down_valid & ~down_ready);
  assign accept      = up_valid & up_ready;
  assign load        = accept & closing;
  // Lanes above cnt are still zero in acc, so unfilled lanes come out as 0.
  assign packed_word = acc | (W'(up_data) << (int'(cnt) * D_WIDTH));

`ifdef PACK_FLUSH_EN
  logic [RATIO-1:0] keep_mask;

  // Lanes 0..cnt carry real data in the word being closed.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < RATIO; i++) begin
      keep_mask[i] = (i <= int'(cnt));
    end
  end

  assign payload_in = {up_last, keep_mask, packed_word};
  assign down_data  = payload[W-1:0];
  assign down_keep  = payload[W +: RATIO];
  assign down_last  = payload[PW-1];
`else
  assign payload_in = packed_word;
  assign down_data  = payload;
`endif

  // Lane counter and accumulator: fill on non-closing accepts, clear on close.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (closing) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          acc[int'(cnt)*D_WIDTH +: D_WIDTH] <= up_data;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  pack_out_reg #(
    .W (PW)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .payload_in (payload_in),
    .sink_ready (down_ready),
    .payload    (payload),
    .valid      (down_valid)
  );

endmodule
